// File: rtl/uart_rx_buf.sv
// rtl/uart_rx_buf.sv - 16x oversampling 8N1-style UART receiver with one-entry holding register
// Frames are recovered on s_tick; the holding register reports valid, framing error and sticky overrun.
module uart_rx_buf #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx_i,
    input  logic       s_tick_i,
    input  logic       rd_i,
    output logic [7:0] dout_o,
    output logic       rx_valid_o,
    output logic       rx_done_tick_o,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [4:0] S_MID   = 5'd7;
    localparam logic [4:0] S_BIT   = 5'd15;
    localparam logic [4:0] S_LAST  = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST  = 3'(DBIT - 1);

    logic            rx_meta_q, rx_s_q;
    logic [1:0]      state_q, state_d;
    logic [4:0]      s_q, s_d;
    logic [2:0]      n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            complete;
    logic [7:0]      b_ext;

    logic [7:0]      dout_q, dout_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;

    // rx is asynchronous to clk; idle-high reset keeps a spurious start out of reset
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        n_d      = n_q;
        b_d      = b_q;
        complete = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d = ST_START;
                    s_d     = '0;
                end
            end
            ST_START: begin
                if (s_tick_i) begin
                    if (s_q == S_MID) begin
                        if (!rx_s_q) begin
                            state_d = ST_DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            ST_DATA: begin
                if (s_tick_i) begin
                    if (s_q == S_BIT) begin
                        s_d = '0;
                        b_d = {rx_s_q, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            default: begin
                if (s_tick_i) begin
                    if (s_q == S_LAST) begin
                        complete = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        b_ext            = '0;
        b_ext[DBIT-1:0]  = b_q;
    end

    // A completion beats a simultaneous read: the new byte is what stays pending
    always_comb begin
        done_d  = complete;
        dout_d  = complete ? b_ext : dout_q;
        ferr_d  = complete ? ~rx_s_q : ferr_q;
        valid_d = complete ? 1'b1 : (rd_i ? 1'b0 : valid_q);
        ovr_d   = ovr_q | (complete & valid_q & ~rd_i);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dout_o         = dout_q;
    assign rx_valid_o     = valid_q;
    assign rx_done_tick_o = done_q;
    assign frame_err_o    = ferr_q;
    assign overrun_o      = ovr_q;

endmodule

// File: tb/tb_uart_rx_buf.sv
// tb/tb_uart_rx_buf.sv - self-checking bench for uart_rx_buf (8N1 and DBIT=7/SB_TICK=32 instances)
module tb_uart_rx_buf;

    logic       clk = 1'b0;
    logic       reset, s_tick, rx_a, rx_b, rd_a, rd_b;
    logic [7:0] dout_a, dout_b;
    logic       valid_a, valid_b, done_a, done_b, ferr_a, ferr_b, ovr_a, ovr_b;
    int         errors = 0;
    int         checks = 0;
    int         ndone_a = 0;
    int         ndone_b = 0;
    int         tick_cnt;

    always #5 clk = ~clk;

    uart_rx_buf dut_a (
        .clk_i(clk), .reset_i(reset), .rx_i(rx_a), .s_tick_i(s_tick), .rd_i(rd_a),
        .dout_o(dout_a), .rx_valid_o(valid_a), .rx_done_tick_o(done_a),
        .frame_err_o(ferr_a), .overrun_o(ovr_a)
    );

    uart_rx_buf #(.DBIT(7), .SB_TICK(32)) dut_b (
        .clk_i(clk), .reset_i(reset), .rx_i(rx_b), .s_tick_i(s_tick), .rd_i(rd_b),
        .dout_o(dout_b), .rx_valid_o(valid_b), .rx_done_tick_o(done_b),
        .frame_err_o(ferr_b), .overrun_o(ovr_b)
    );

    // s_tick every 4 clk gives 64 clk per bit
    initial begin
        tick_cnt = 0;
        s_tick   = 1'b0;
        forever begin
            @(negedge clk);
            tick_cnt = (tick_cnt + 1) % 4;
            s_tick   = (tick_cnt == 0);
        end
    end

    always @(posedge clk) begin
        if (done_a) ndone_a <= ndone_a + 1;
        if (done_b) ndone_b <= ndone_b + 1;
    end

    initial begin
        #3_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_rx(input bit which, input logic v);
        if (which) rx_b = v;
        else       rx_a = v;
    endtask

    // A bad frame drives its stop bit low for 48 clk only, so the line is high again before any re-start validates
    task automatic send_frame(input bit which, input logic [7:0] data, input int nbits,
                              input bit stop_ok, input int stop_clk);
        set_rx(which, 1'b0);
        wait_clk(64);
        for (int i = 0; i < nbits; i++) begin
            set_rx(which, data[i]);
            wait_clk(64);
        end
        if (stop_ok) begin
            set_rx(which, 1'b1);
            wait_clk(stop_clk);
        end else begin
            set_rx(which, 1'b0);
            wait_clk(48);
            set_rx(which, 1'b1);
            wait_clk(64);
        end
    endtask

    task automatic check_a(input string tag, input logic [7:0] d, input bit v, input bit fe, input bit ov);
        check({tag, ".dout"},      32'(dout_a),  32'(d));
        check({tag, ".rx_valid"},  32'(valid_a), 32'(v));
        check({tag, ".frame_err"}, 32'(ferr_a),  32'(fe));
        check({tag, ".overrun"},   32'(ovr_a),   32'(ov));
    endtask

    task automatic pulse_rd_a(input string tag);
        rd_a = 1'b1;
        @(negedge clk);
        rd_a = 1'b0;
        check({tag, ".valid_after_rd"}, 32'(valid_a), 0);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         rd_before;
        logic [7:0] exp_dout;
        bit         exp_valid;
        bit         exp_ferr;
        bit         exp_ovr;
    } vec_t;

    vec_t       vecs[4];
    int         base;
    logic [7:0] c3;
    logic [7:0] m_dout;
    bit         m_valid, m_ferr, m_ovr;

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h11, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h22, 1'b0, 8'h22, 1'b1, 1'b0, 1'b1};

        reset = 1'b1; rx_a = 1'b1; rx_b = 1'b1; rd_a = 1'b0; rd_b = 1'b0;
        wait_clk(5);
        check_a("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        check("reset.done", 32'(done_a), 0);
        check("reset.dout_b", 32'(dout_b), 0);
        check("reset.valid_b", 32'(valid_b), 0);
        reset = 1'b0;
        wait_clk(20);

        for (int i = 0; i < 4; i++) begin
            if (vecs[i].rd_before) pulse_rd_a($sformatf("vec%0d", i));
            base = ndone_a;
            send_frame(1'b0, vecs[i].data, 8, 1'b1, 64);
            wait_clk(8);
            check($sformatf("vec%0d.done_count", i), 32'(ndone_a - base), 1);
            check_a($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_valid,
                    vecs[i].exp_ferr, vecs[i].exp_ovr);
        end
        pulse_rd_a("ovr_read");
        check("ovr_read.overrun_sticky", 32'(ovr_a), 1);

        base = ndone_a;
        rx_a = 1'b0;
        wait_clk(20);
        rx_a = 1'b1;
        wait_clk(200);
        check("false_start.done_count", 32'(ndone_a - base), 0);

        base = ndone_a;
        send_frame(1'b0, 8'h55, 8, 1'b0, 64);
        wait_clk(8);
        check("bad_stop.done_count", 32'(ndone_a - base), 1);
        check_a("bad_stop", 8'h55, 1'b1, 1'b1, 1'b1);

        base = ndone_a;
        rx_a = 1'b0;
        wait_clk(1600);
        check("break.done_count", 32'(ndone_a - base), 2);
        check_a("break", 8'h00, 1'b1, 1'b1, 1'b1);
        rx_a = 1'b1;
        reset = 1'b1;
        wait_clk(4);
        check_a("break_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        base = ndone_a;
        wait_clk(700);
        check("after_reset.done_count", 32'(ndone_a - base), 0);

        send_frame(1'b0, 8'h96, 8, 1'b1, 64);
        wait_clk(8);
        check_a("pre_abort", 8'h96, 1'b1, 1'b0, 1'b0);

        c3 = 8'hC3;
        base = ndone_a;
        for (int slot = 0; slot < 10; slot++) begin
            rx_a = (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : c3[slot-1];
            wait_clk(32);
            if (slot == 4) begin
                reset = 1'b1;
                #1;
                check_a("abort_async", 8'h00, 1'b0, 1'b0, 1'b0);
                check("abort_async.done", 32'(done_a), 0);
            end
            if (slot == 7) reset = 1'b0;
            wait_clk(32);
        end
        wait_clk(64);
        check("abort.done_count", 32'(ndone_a - base), 0);
        base = ndone_a;
        send_frame(1'b0, 8'hC3, 8, 1'b1, 64);
        wait_clk(8);
        check("fresh.done_count", 32'(ndone_a - base), 1);
        check_a("fresh", 8'hC3, 1'b1, 1'b0, 1'b0);

        // rd lands exactly on the completion cycle: 2 clk sync + 1 clk to start, then 8+16*8+16 ticks
        fork
            send_frame(1'b0, 8'h5A, 8, 1'b1, 64);
            begin
                int cnt = 0;
                bit hit = 1'b0;
                repeat (3) @(posedge clk);
                for (int k = 0; k < 3000 && !hit; k++) begin
                    @(negedge clk);
                    #1;
                    if (s_tick) cnt++;
                    if (cnt == 152) begin
                        rd_a = 1'b1;
                        @(negedge clk);
                        #1;
                        check("coincide.done_latency", 32'(done_a), 1);
                        rd_a = 1'b0;
                        hit = 1'b1;
                    end
                end
                if (!hit) check("coincide.timeout", 0, 1);
            end
        join
        wait_clk(8);
        check_a("coincide", 8'h5A, 1'b1, 1'b0, 1'b0);

        m_dout = 8'h5A; m_valid = 1'b1; m_ferr = 1'b0; m_ovr = 1'b0;
        for (int i = 0; i < 24; i++) begin
            logic [7:0] data;
            bit         stop_ok, rdb;
            data    = 8'($urandom);
            stop_ok = ($urandom_range(0, 3) != 0);
            rdb     = 1'($urandom_range(0, 1));
            if (rdb) begin
                pulse_rd_a($sformatf("rand%0d", i));
                m_valid = 1'b0;
            end
            base = ndone_a;
            send_frame(1'b0, data, 8, stop_ok, 64);
            wait_clk(8 + int'($urandom_range(0, 40)));
            m_ovr   = m_ovr | m_valid;
            m_valid = 1'b1;
            m_dout  = data;
            m_ferr  = !stop_ok;
            check($sformatf("rand%0d.done_count", i), 32'(ndone_a - base), 1);
            check_a($sformatf("rand%0d", i), m_dout, m_valid, m_ferr, m_ovr);
        end

        base = ndone_b;
        send_frame(1'b1, 8'hFF, 7, 1'b1, 128);
        check("p7a.dout", 32'(dout_b), 32'h7F);
        check("p7a.frame_err", 32'(ferr_b), 0);
        check("p7a.rx_valid", 32'(valid_b), 1);
        send_frame(1'b1, 8'hAA, 7, 1'b1, 128);
        check("p7b.dout", 32'(dout_b), 32'h2A);
        check("p7b.frame_err", 32'(ferr_b), 0);
        check("p7b.overrun", 32'(ovr_b), 1);
        check("p7.done_count", 32'(ndone_b - base), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_buf.md
# uart_rx_buf

Buffered UART receiver for the serial link, the receive end of the 8N1 byte link used between the two boards. It samples the serial line at 16× oversampling using the shared baud-rate tick, and recovers each frame (start bit, DBIT data bits LSB-first, stop bit). The recovered byte goes into a one-entry holding register with valid/read handshake, framing-error and overrun flags. It sits between the pad input and the game-control logic, driven by the same baud tick generator as the transmitter.

## Interface
- DBIT, 8, data bits per frame, 5..8
- SB_TICK, 16, s_tick count for the stop bit: 16 = 1 bit, 24 = 1.5 bits, 32 = 2 bits. Maximum 32.
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-high reset
- rx  input  1  serial line, asynchronous to clk, idle high
- s_tick  input  1  one-clk pulse at 16× baud rate
- rd  input  1  consumer read strobe; clears rx_valid
- dout  output  8  last received byte; DBIT bits right-aligned, upper bits 0
- rx_valid  output  1  holding register contains an unread byte
- rx_done_tick  output  1  one-clk pulse when a frame completes, good or bad
- frame_err  output  1  stop bit of the last completed frame sampled low
- overrun  output  1  sticky; a frame completed while rx_valid was already 1

## Operation
- **Input synchroniser.** rx passes through a 2-flop synchroniser; both flops reset to 1. The FSM sees only the synchronised value rx_s.
- **FSM states.** idle, start, data, stop. All counters advance only on cycles with s_tick=1.
- **idle.**
  - On rx_s=0: go to start and clear the tick counter s.
  - s_tick is not required for this transition.
- **start.**
  - On s_tick with s=7 (mid start bit):
    - rx_s=0: go to data, s=0, n=0.
    - rx_s=1 (glitch / false start): return to idle with no flag and no done pulse.
  - Otherwise s increments.
- **data.**
  - On s_tick with s=15:
    - s=0.
    - Shift register b (DBIT wide) becomes {rx_s, b[DBIT-1:1]}, so the first bit received ends in bit 0.
    - If n=DBIT-1, go to stop; else n increments.
  - Otherwise s increments.
- **stop.**
  - On s_tick with s=SB_TICK-1:
    - Sample rx_s.
    - Pulse rx_done_tick for that one cycle (registered, so it appears the following clk).
    - Load dout with zero-extended b.
    - Set frame_err to ~rx_s.
    - Go to idle.
  - Otherwise s increments.
- **Counter widths.** s is 5 bits. n is 3 bits. Neither wraps within a state.
- **Holding register.**
  - On completion, rx_valid is set to 1.
  - If rx_valid was already 1 and rd is not asserted in the same cycle, overrun is set to 1; the new byte still overwrites dout (newest data wins).
  - rd=1 clears rx_valid.
  - rd together with a completion in the same cycle: the completion wins, so rx_valid=1 and overrun is not set.
  - overrun clears only on reset.
  - frame_err is updated at every completion and otherwise holds.
- **Framing errors.** A bad frame still sets rx_valid, so the consumer inspects frame_err.
- **Break condition (rx held low).** After a framing error the FSM returns to idle. It immediately re-enters start and produces repeated frame_err completions with dout=0.

## Timing
- **Reset values.**
  - dout=0, rx_valid=0, rx_done_tick=0, frame_err=0, overrun=0.
  - FSM in idle; s=0, n=0, b=0; synchroniser flops =1.
- **Reset mid-frame.** Aborts the frame immediately. No done pulse occurs after reset is released until a new full frame arrives.
- **Latency.** Falling edge on rx is visible to the FSM 2 clk later. The start bit is validated 8 s_ticks after detection.
- **Frame completion.** Completion occurs at the s_tick ending the stop-bit interval (8+16·DBIT+SB_TICK s_ticks after detection). The outputs update on the following clk edge.
- **Output relationship.** rx_done_tick, dout, rx_valid and frame_err all change on the same clk edge.
- **rx_done_tick.** Exactly one clk wide, regardless of the s_tick spacing.
- **rd.**
  - Sampled on any clk edge; no s_tick dependency.
  - rd with rx_valid=0 is a no-op.

## Test plan
- **Single good frame.** s_tick every 4 clk; send 0xA5, 8N1, at 64 clk/bit. Required: one rx_done_tick; dout=0xA5, rx_valid=1, frame_err=0.
- **Read handshake.** After 0xA5 is received, pulse rd for 1 clk, then send 0x3C. Required: rx_valid drops the cycle after rd; after the second frame dout=0x3C, rx_valid=1, overrun=0.
- **Overrun.** Send 0x11 then 0x22 with no rd. Required: overrun=1, dout=0x22, rx_valid=1. Then rd → rx_valid=0 and overrun stays 1.
- **False start and framing error.**
  - Drive rx low for 5 s_ticks, then high. Required: no done pulse, FSM back in idle.
  - Then send 0x55 with the stop bit low. Required: done pulse, dout=0x55, frame_err=1.
- **Parameter variant.** DBIT=7, SB_TICK=32. Send 0x7F followed by 2 stop bits. Required: dout=0x7F, frame_err=0. A second frame starting immediately after the stop bits is received correctly.
- **Reset mid-frame.** Assert reset during data bit 3 of a frame.
  - Required: all outputs 0 immediately (asynchronous).
  - After reset is released and the rest of the aborted frame (through its stop bit) has passed, a fresh 0xC3 frame yields dout=0xC3 and exactly one done pulse.
